// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter.
// Bytes are pushed through a valid/ready handshake; the transmitter pops the
// head byte whenever it is idle or finishing a stop bit, so queued bytes go
// out back-to-back with no idle gap on the line.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef logic [AW:0]   cnt_t;
    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] clk_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t    state;
    state_t    state_next;

    logic [7:0] mem [FIFO_DEPTH];
    ptr_t       wr_ptr;
    ptr_t       rd_ptr;

    clk_cnt_t   clk_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;

    logic       bit_done;
    logic       push;
    logic       pop;
    logic       fifo_empty;

    assign bit_done   = (clk_cnt == clk_cnt_t'(CLKS_PER_BIT - 1));
    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = (fifo_count < cnt_t'(FIFO_DEPTH));
    assign push       = in_valid && in_ready;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state and pop decision; a pop always coincides with entering START
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = START;
                    pop        = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_done && (bit_cnt == 3'd7)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (!fifo_empty) begin
                        state_next = START;
                        pop        = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: line level follows the state, busy covers queued bytes too
    always_comb begin
        tx   = 1'b1;
        busy = (state != IDLE) || !fifo_empty;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[0];
            default: tx = 1'b1;
        endcase
    end

    // Bit timing and shift register; a pop reloads the byte and restarts timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (pop) begin
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= mem[rd_ptr];
        end else if (state != IDLE) begin
            if (bit_done) begin
                clk_cnt <= '0;
                if (state == DATA) begin
                    shreg   <= {1'b1, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end else begin
                clk_cnt <= clk_cnt + clk_cnt_t'(1);
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + cnt_t'(1);
                2'b01:   fifo_count <= fifo_count - cnt_t'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: a default-rate instance for exact line timing
// and a fast-rate instance streamed through a behavioural line receiver.
module tb_uart_tx_fifo;

    localparam int CPB    = 50000000 / 115200;   // 434
    localparam int F_CPB  = 1000000 / 100000;    // 10

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-rate instance
    logic       rst_n    = 1'b0;
    logic [7:0] in_data  = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic [4:0] fifo_count;

    // fast-rate instance
    logic       f_rst_n    = 1'b0;
    logic [7:0] f_in_data  = '0;
    logic       f_in_valid = 1'b0;
    logic       f_in_ready;
    logic       f_tx;
    logic       f_busy;
    logic [4:0] f_fifo_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] rx_q[$];
    int         rx_ferr = 0;

    uart_tx_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_tx_fifo #(
        .CLK_FREQ   (1000000),
        .BAUD       (100000),
        .FIFO_DEPTH (16)
    ) dut_fast (
        .clk        (clk),
        .rst_n      (f_rst_n),
        .in_data    (f_in_data),
        .in_valid   (f_in_valid),
        .in_ready   (f_in_ready),
        .tx         (f_tx),
        .busy       (f_busy),
        .fifo_count (f_fifo_count)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Line receiver for the fast instance: finds the start bit, samples each
    // bit at its centre and records the decoded byte.
    initial begin
        logic [7:0] r;
        forever begin
            @(posedge clk);
            #1;
            if (f_rst_n === 1'b1 && f_tx === 1'b0) begin
                tick(F_CPB / 2);
                if (f_tx !== 1'b0) rx_ferr++;
                for (int k = 0; k < 8; k++) begin
                    tick(F_CPB);
                    r[k] = f_tx;
                end
                tick(F_CPB);
                if (f_tx !== 1'b1) rx_ferr++;
                rx_q.push_back(r);
            end
        end
    end

    // Checks one whole frame on the default instance, starting in its first cycle.
    task automatic expect_frame(input logic [7:0] b, input string nm);
        logic [9:0] bits;
        int good;
        int busy_hi;
        bits    = {1'b1, b, 1'b0};
        busy_hi = 0;
        for (int i = 0; i < 10; i++) begin
            good = 0;
            for (int c = 0; c < CPB; c++) begin
                if (tx === bits[i]) good++;
                if (busy === 1'b1) busy_hi++;
                tick(1);
            end
            vectors++;
            if (good !== CPB) begin
                miscompares++;
                $display("FAIL %s bit%0d: held %0d cycles at level %0b, required %0d", nm, i, good, bits[i], CPB);
            end
        end
        vectors++;
        if (busy_hi !== 10 * CPB) begin
            miscompares++;
            $display("FAIL %s busy: high %0d cycles, required %0d", nm, busy_hi, 10 * CPB);
        end
    endtask

    // Offers one byte to the fast instance and waits for it to be taken.
    task automatic f_send(input logic [7:0] b, output logic ok);
        int guard;
        f_in_data  = b;
        f_in_valid = 1'b1;
        guard      = 0;
        while (f_in_ready !== 1'b1 && guard < 5000) begin
            tick(1);
            guard++;
        end
        ok = (guard < 5000);
        if (ok) tick(1);
        f_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        f_rst_n = 1'b0;
        tick(3);
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %0b, expected 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
        vectors++; if (fifo_count !== 5'd0) begin miscompares++; $display("FAIL reset_count: got %0d, expected 0", fifo_count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0b, expected 1", in_ready); end
        vectors++; if (f_tx !== 1'b1) begin miscompares++; $display("FAIL reset_fast_tx: got %0b, expected 1", f_tx); end
        rst_n   = 1'b1;
        f_rst_n = 1'b1;
        tick(2);
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL post_reset_tx: got %0b, expected 1", tx); end
    endtask

    task automatic test_single_byte();
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        vectors++; if (fifo_count !== 5'd1) begin miscompares++; $display("FAIL single_count_after_push: got %0d, expected 1", fifo_count); end
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_latency_tx: got %0b, expected 1", tx); end
        tick(1);
        vectors++; if (fifo_count !== 5'd0) begin miscompares++; $display("FAIL single_count_after_pop: got %0d, expected 0", fifo_count); end
        expect_frame(8'hA5, "single_a5");
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL single_idle_tx: got %0b, expected 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end: got %0b, expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        in_data  = 8'h00;
        in_valid = 1'b1;
        tick(1);
        in_data  = 8'hFF;
        tick(1);
        in_valid = 1'b0;
        vectors++; if (fifo_count !== 5'd1) begin miscompares++; $display("FAIL b2b_count: got %0d, expected 1", fifo_count); end
        expect_frame(8'h00, "b2b_first");
        expect_frame(8'hFF, "b2b_second");
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL b2b_idle_tx: got %0b, expected 1", tx); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_end: got %0b, expected 0", busy); end
    endtask

    task automatic test_full();
        logic [7:0] b [18];
        for (int i = 0; i < 18; i++) b[i] = 8'($urandom);
        in_data  = b[0];
        in_valid = 1'b1;
        tick(1);
        in_data  = b[1];
        tick(1);
        fork
            expect_frame(b[0], "full_frame0");
            begin
                for (int k = 2; k <= 16; k++) begin
                    in_data = b[k];
                    tick(1);
                end
                vectors++; if (fifo_count !== 5'd16) begin miscompares++; $display("FAIL full_count: got %0d, expected 16", fifo_count); end
                vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %0b, expected 0", in_ready); end
                in_data = b[17];
                tick(100);
                vectors++; if (fifo_count !== 5'd16) begin miscompares++; $display("FAIL full_ignored_count: got %0d, expected 16", fifo_count); end
                vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ignored_ready: got %0b, expected 0", in_ready); end
            end
        join
        vectors++; if (fifo_count !== 5'd15) begin miscompares++; $display("FAIL full_after_pop_count: got %0d, expected 15", fifo_count); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL full_after_pop_ready: got %0b, expected 1", in_ready); end
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL full_next_start: got %0b, expected 0", tx); end
        tick(1);
        in_valid = 1'b0;
        vectors++; if (fifo_count !== 5'd16) begin miscompares++; $display("FAIL full_late_accept: got %0d, expected 16", fifo_count); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (fifo_count !== 5'd0) begin miscompares++; $display("FAIL full_reset_count: got %0d, expected 0", fifo_count); end
        tick(1);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_simultaneous(output logic [7:0] second);
        logic [7:0] c [5];
        for (int i = 0; i < 5; i++) c[i] = 8'($urandom);
        second = c[1];
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = c[i];
            tick(1);
        end
        in_valid = 1'b0;
        vectors++; if (fifo_count !== 5'd3) begin miscompares++; $display("FAIL simul_count_before: got %0d, expected 3", fifo_count); end
        tick(10 * CPB - 3);
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL simul_stop_bit: got %0b, expected 1", tx); end
        in_data  = c[4];
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        vectors++; if (fifo_count !== 5'd3) begin miscompares++; $display("FAIL simul_count_after: got %0d, expected 3", fifo_count); end
        vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL simul_next_start: got %0b, expected 0", tx); end
    endtask

    task automatic test_reset_mid_frame(input logic [7:0] cur);
        int good;
        logic exp_bit;
        tick(5 * CPB + 200);
        exp_bit = cur[4];
        vectors++; if (tx !== exp_bit) begin miscompares++; $display("FAIL midframe_bit4: got %0b, expected %0b", tx, exp_bit); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL midframe_reset_tx: got %0b, expected 1", tx); end
        vectors++; if (fifo_count !== 5'd0) begin miscompares++; $display("FAIL midframe_reset_count: got %0d, expected 0", fifo_count); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midframe_reset_busy: got %0b, expected 0", busy); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midframe_reset_ready: got %0b, expected 1", in_ready); end
        tick(2);
        rst_n = 1'b1;
        good  = 0;
        for (int i = 0; i < 2000; i++) begin
            if (tx === 1'b1 && busy === 1'b0) good++;
            tick(1);
        end
        vectors++; if (good !== 2000) begin miscompares++; $display("FAIL midframe_quiet: got %0d idle cycles, expected 2000", good); end
    endtask

    // Streams a byte list through the fast instance and compares what the
    // receiver decodes against the list itself.
    task automatic run_stream(input logic [7:0] exp_q[$], input int max_gap, input string nm);
        logic ok;
        int   guard;
        int   ferr0;
        int   n;
        n     = exp_q.size();
        rx_q.delete();
        ferr0 = rx_ferr;
        foreach (exp_q[i]) begin
            f_send(exp_q[i], ok);
            if (!ok) begin
                vectors++;
                miscompares++;
                $display("FAIL %s handshake_timeout: byte %0d not accepted, expected acceptance", nm, i);
                break;
            end
            if (max_gap > 0) tick($urandom_range(max_gap, 0));
        end
        guard = 0;
        while (rx_q.size() < n && guard < n * 10 * F_CPB + 1000) begin
            tick(1);
            guard++;
        end
        tick(F_CPB);
        vectors++; if (rx_q.size() !== n) begin miscompares++; $display("FAIL %s rx_count: got %0d, expected %0d", nm, rx_q.size(), n); end
        for (int i = 0; i < n && i < rx_q.size(); i++) begin
            vectors++;
            if (rx_q[i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s byte%0d: got %02h, expected %02h", nm, i, rx_q[i], exp_q[i]);
            end
        end
        vectors++; if (rx_ferr !== ferr0) begin miscompares++; $display("FAIL %s framing: got %0d errors, expected 0", nm, rx_ferr - ferr0); end
        vectors++; if (f_busy !== 1'b0) begin miscompares++; $display("FAIL %s busy_end: got %0b, expected 0", nm, f_busy); end
        vectors++; if (f_fifo_count !== 5'd0) begin miscompares++; $display("FAIL %s count_end: got %0d, expected 0", nm, f_fifo_count); end
    endtask

    task automatic test_pointer_wrap();
        logic [7:0] q[$];
        for (int i = 0; i < 40; i++) q.push_back(8'(i));
        run_stream(q, 0, "wrap");
    endtask

    task automatic test_random_stream();
        logic [7:0] q[$];
        for (int i = 0; i < 60; i++) q.push_back(8'($urandom));
        run_stream(q, 25, "random");
    endtask

    initial begin
        logic [7:0] second;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_full();
        test_simultaneous(second);
        test_reset_mid_frame(second);
        test_pointer_wrap();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
